// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating frame accumulator for multiplier products
// Sums a frame of 2*WIDTH products into an ACC_WIDTH result, one result per frame.
`timescale 1ns/1ps
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int MAX_TERMS = 16,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_product,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CW-1:0]        out_count,
  output logic                 out_overflow,
  output logic                 out_truncated
);

  localparam int EXT = ACC_WIDTH + 1 - 2*WIDTH;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CW-1:0]        count_q;
  logic                 mode_q;
  logic                 ovf_q;

  logic                 accept;
  logic                 frame_signed;
  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   acc_ext;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 sat;
  logic [CW-1:0]        count_inc;
  logic                 at_limit;
  logic                 close;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_OUTPUT);

  assign accept       = in_valid && in_ready && !clr;
  // Frame mode is taken from the first beat; later in_signed values are ignored.
  assign frame_signed = (count_q == '0) ? in_signed : mode_q;
  assign count_inc    = count_q + CW'(1);
  assign at_limit     = (count_inc == CW'(MAX_TERMS));
  assign close        = accept && (in_last || at_limit);

  always_comb begin
    prod_ext = '0;
    acc_ext  = '0;
    sum      = '0;
    acc_next = '0;
    sat      = 1'b0;
    if (frame_signed) begin
      prod_ext = {{EXT{in_product[2*WIDTH-1]}}, in_product};
      acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
    end else begin
      prod_ext = {{EXT{1'b0}}, in_product};
      acc_ext  = {1'b0, acc_q};
    end
    sum      = acc_ext + prod_ext;
    acc_next = sum[ACC_WIDTH-1:0];
    // Both operands fit in ACC_WIDTH bits, so one extra bit exposes any overflow.
    if (frame_signed) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        sat      = 1'b1;
        acc_next = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (sum[ACC_WIDTH]) begin
      sat      = 1'b1;
      acc_next = {ACC_WIDTH{1'b1}};
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM:  if (close)     state_d = ST_OUTPUT;
        ST_OUTPUT: if (out_ready) state_d = ST_ACCUM;
        default:                  state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      count_q       <= '0;
      mode_q        <= 1'b0;
      ovf_q         <= 1'b0;
      out_acc       <= '0;
      out_count     <= '0;
      out_overflow  <= 1'b0;
      out_truncated <= 1'b0;
    end else if (clr) begin
      acc_q   <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (out_valid && out_ready) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      acc_q   <= acc_next;
      count_q <= count_inc;
      mode_q  <= frame_signed;
      ovf_q   <= ovf_q | sat;
      if (close) begin
        out_acc       <= acc_next;
        out_count     <= count_inc;
        out_overflow  <= ovf_q | sat;
        out_truncated <= !in_last;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized and directed bench for product_accumulator
`timescale 1ns/1ps
module tb_product_accumulator;

  localparam int W    = 8;
  localparam int A    = 17;
  localparam int MAXT = 4;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [63:0] MASK = (64'd1 << A) - 64'd1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*W-1:0]    in_product = '0;
  logic              in_signed = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [A-1:0]      out_acc;
  logic [CW-1:0]     out_count;
  logic              out_overflow;
  logic              out_truncated;

  int n_checks = 0;
  int n_fail   = 0;

  product_accumulator #(.WIDTH(W), .ACC_WIDTH(A), .MAX_TERMS(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_overflow(out_overflow), .out_truncated(out_truncated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: true arithmetic value of the running sum, clamped to the frame's range.
  logic   m_out = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;
  logic   m_sgn = 1'b0;
  logic   m_ovf = 1'b0;
  longint e_acc = 0;
  int     e_cnt = 0;
  logic   e_ovf = 1'b0;
  logic   e_trn = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    longint pv, s, hi_v, lo_v;
    logic sg, ov;
    int c;
    logic signed [2*W-1:0] ps;
    if (!rst_n) begin
      m_out <= 1'b0; m_acc <= 0; m_cnt <= 0; m_sgn <= 1'b0; m_ovf <= 1'b0;
      e_acc <= 0; e_cnt <= 0; e_ovf <= 1'b0; e_trn <= 1'b0;
    end else if (clr) begin
      m_out <= 1'b0; m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
    end else if (m_out) begin
      if (out_ready) begin
        m_out <= 1'b0; m_acc <= 0; m_cnt <= 0; m_ovf <= 1'b0;
      end
    end else if (in_valid) begin
      sg   = (m_cnt == 0) ? in_signed : m_sgn;
      ps   = in_product;
      pv   = sg ? longint'(ps) : longint'(in_product);
      hi_v = sg ? (longint'(1) <<< (A-1)) - 1 : (longint'(1) <<< A) - 1;
      lo_v = sg ? -(longint'(1) <<< (A-1)) : 0;
      s    = m_acc + pv;
      ov   = m_ovf;
      if (s > hi_v) begin s = hi_v; ov = 1'b1; end
      else if (s < lo_v) begin s = lo_v; ov = 1'b1; end
      c = m_cnt + 1;
      m_acc <= s; m_cnt <= c; m_sgn <= sg; m_ovf <= ov;
      if (in_last || c == MAXT) begin
        m_out <= 1'b1; e_acc <= s; e_cnt <= c; e_ovf <= ov; e_trn <= !in_last;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_acc", 64'(out_acc), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!m_out));
      chk("out_valid", 64'(out_valid), 64'(m_out));
      if (m_out) begin
        chk("out_acc", 64'(out_acc), 64'(e_acc) & MASK);
        chk("out_count", 64'(out_count), 64'(e_cnt));
        chk("out_overflow", 64'(out_overflow), 64'(e_ovf));
        chk("out_truncated", 64'(out_truncated), 64'(e_trn));
      end
    end
  end

  task automatic beat(input logic [2*W-1:0] p, input logic s, input logic l);
    int n = 0;
    in_valid = 1'b1; in_product = p; in_signed = s; in_last = l;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("beat_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(input logic [A-1:0] ea, input int ec, input logic eo,
                             input logic et, input int stall, input logic ack);
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("res_valid", 64'(out_valid), 64'd1);
    chk("res_acc", 64'(out_acc), 64'(ea));
    chk("res_count", 64'(out_count), 64'(ec));
    chk("res_overflow", 64'(out_overflow), 64'(eo));
    chk("res_truncated", 64'(out_truncated), 64'(et));
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_acc", 64'(out_acc), 64'(ea));
    end
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    beat(16'h00FF, 1'b0, 1'b0);
    beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b1);
    chk("t1_latency", 64'(out_valid), 64'd1);
    wait_result(17'h00200, 3, 1'b0, 1'b0, 0, 1'b1);

    beat(16'hFF80, 1'b1, 1'b0);
    beat(16'h0010, 1'b0, 1'b1);
    wait_result(17'h1FF90, 2, 1'b0, 1'b0, 5, 1'b1);

    for (int i = 0; i < 3; i++) beat(16'hFE01, 1'b0, i == 2);
    wait_result(17'h1FFFF, 3, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) beat(16'h4000, 1'b1, i == 3);
    wait_result(17'h0FFFF, 4, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) beat(16'hC000, 1'b1, i == 3);
    wait_result(17'h10000, 4, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) beat(16'h8000, 1'b1, i == 2);
    wait_result(17'h10000, 3, 1'b1, 1'b0, 0, 1'b1);

    for (int i = 0; i < 4; i++) beat(16'h0001, 1'b0, 1'b0);
    wait_result(17'h00004, 4, 1'b0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 4; i++) beat(16'h0001, 1'b0, 1'b0);
    wait_result(17'h00004, 4, 1'b0, 1'b1, 0, 1'b1);

    beat(16'h0005, 1'b0, 1'b0);
    beat(16'h0005, 1'b0, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_product = 16'h0005;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("clr_no_result", 64'(out_valid), 64'd0);
    end
    beat(16'h0007, 1'b0, 1'b1);
    wait_result(17'h00007, 1, 1'b0, 1'b0, 0, 1'b1);

    beat(16'h0003, 1'b0, 1'b1);
    wait_result(17'h00003, 1, 1'b0, 1'b0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_acc", 64'(out_acc), 64'd0);
    chk("arst_out_count", 64'(out_count), 64'd0);
    chk("arst_flags", 64'({out_overflow, out_truncated}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(16'h0002, 1'b0, 1'b1);
    wait_result(17'h00002, 1, 1'b0, 1'b0, 0, 1'b1);
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    beat(16'h0009, 1'b0, 1'b0);
    beat(16'h0001, 1'b0, 1'b1);
    wait_result(17'h0000A, 2, 1'b0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r          = $urandom_range(0, 3);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_signed  = 1'($urandom_range(0, 1));
      in_last    = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 9) < 6);
      clr        = ($urandom_range(0, 49) == 0);
      in_product = (r == 0) ? 16'($urandom_range(0, 15)) :
                   (r == 1) ? (16'hFE01 ^ 16'($urandom_range(0, 3))) :
                   (r == 2) ? (16'h8000 | 16'($urandom_range(0, 255))) : 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
